fp_norm_round: RTL and testbench

Normalize-and-round stage sitting directly downstream of the mantissa multiply/divide unit in the single-precision FP datapath. Takes the raw 48-bit mantissa product or 27-bit quotient with the precomputed sign and biased exponent, normalizes, rounds to nearest-even, and handles overflow and underflow. Packs an IEEE-754 binary32 result. Two-stage pipeline with valid/ready handshakes on both sides, throughput one op per cycle.

---
 rtl/fp_norm_round.sv | 155 +++++++++++++++
 tb/tb_fp_norm_round.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/fp_norm_round.sv
// Normalize / round-to-nearest-even / pack stage for the binary32 mul/div datapath.
// Two-stage valid/ready pipeline: p1 holds the normalized operand, p2 the packed result.
`timescale 1ns/1ps
module fp_norm_round #(
  parameter bit ROUND_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        op_sel,
  input  logic        sign_in,
  input  logic [9:0]  exp_in,
  input  logic [47:0] product_in,
  input  logic [26:0] quotient_in,
  input  logic        div_rem_nz,
  input  logic        bypass,
  input  logic [31:0] bypass_result,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        flag_overflow,
  output logic        flag_underflow,
  output logic        flag_inexact
);

  // Returns {carry, frac}; carry means the mantissa rolled over to 2.0.
  function automatic logic [23:0] round_frac(input logic [22:0] frac,
                                             input logic guard,
                                             input logic sticky);
    logic up;
    up = ROUND_EN & guard & (sticky | frac[0]);
    return {1'b0, frac} + {23'd0, up};
  endfunction

  logic        s2_en;
  logic        s1_en;

  logic        vld_p1;
  logic        sign_p1;
  logic signed [10:0] exp_p1;
  logic [22:0] frac_p1;
  logic        guard_p1;
  logic        sticky_p1;
  logic        byp_p1;
  logic [31:0] byp_res_p1;

  logic signed [10:0] exp_ext;
  logic signed [10:0] exp_n;
  logic [22:0] frac_n;
  logic        guard_n;
  logic        sticky_n;

  logic [23:0]        rnd;
  logic signed [10:0] exp_r;
  logic [31:0]        result_n;
  logic               ovf_n;
  logic               unf_n;
  logic               inx_n;

  assign s2_en    = !out_valid | out_ready;
  assign s1_en    = !vld_p1 | s2_en;
  assign in_ready = s1_en;

  // Stage 0 -> 1: pick the source and shift so the leading one is implicit.
  always_comb begin
    exp_ext  = $signed({exp_in[9], exp_in});
    exp_n    = exp_ext;
    frac_n   = '0;
    guard_n  = 1'b0;
    sticky_n = 1'b0;
    if (!op_sel) begin
      if (product_in[47]) begin
        frac_n   = product_in[46:24];
        guard_n  = product_in[23];
        sticky_n = |product_in[22:0];
        exp_n    = exp_ext + 11'sd1;
      end else begin
        frac_n   = product_in[45:23];
        guard_n  = product_in[22];
        sticky_n = |product_in[21:0];
      end
    end else begin
      if (quotient_in[26]) begin
        frac_n   = quotient_in[25:3];
        guard_n  = quotient_in[2];
        sticky_n = (|quotient_in[1:0]) | div_rem_nz;
      end else begin
        frac_n   = quotient_in[24:2];
        guard_n  = quotient_in[1];
        sticky_n = quotient_in[0] | div_rem_nz;
        exp_n    = exp_ext - 11'sd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
    end else if (s1_en) begin
      vld_p1 <= in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (s1_en) begin
      sign_p1    <= sign_in;
      exp_p1     <= exp_n;
      frac_p1    <= frac_n;
      guard_p1   <= guard_n;
      sticky_p1  <= sticky_n;
      byp_p1     <= bypass;
      byp_res_p1 <= bypass_result;
    end
  end

  // Stage 1 -> 2: round, then resolve overflow / flush-to-zero and pack.
  always_comb begin
    rnd      = round_frac(frac_p1, guard_p1, sticky_p1);
    exp_r    = exp_p1 + $signed({10'd0, rnd[23]});
    result_n = {sign_p1, exp_r[7:0], rnd[22:0]};
    ovf_n    = 1'b0;
    unf_n    = 1'b0;
    inx_n    = guard_p1 | sticky_p1;
    if (byp_p1) begin
      result_n = byp_res_p1;
      inx_n    = 1'b0;
    end else if (exp_r >= 11'sd255) begin
      result_n = {sign_p1, 8'hFF, 23'h0};
      ovf_n    = 1'b1;
      inx_n    = 1'b1;
    end else if (exp_r <= 11'sd0) begin
      result_n = {sign_p1, 31'h0};
      unf_n    = 1'b1;
      inx_n    = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid      <= 1'b0;
      result         <= '0;
      flag_overflow  <= 1'b0;
      flag_underflow <= 1'b0;
      flag_inexact   <= 1'b0;
    end else if (s2_en) begin
      out_valid      <= vld_p1;
      result         <= result_n;
      flag_overflow  <= ovf_n;
      flag_underflow <= unf_n;
      flag_inexact   <= inx_n;
    end
  end

endmodule

// File: tb/tb_fp_norm_round.sv
// Directed bench for fp_norm_round: arithmetic vectors, backpressure stream, async reset.
`timescale 1ns/1ps
module tb_fp_norm_round;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        op_sel;
  logic        sign_in;
  logic [9:0]  exp_in;
  logic [47:0] product_in;
  logic [26:0] quotient_in;
  logic        div_rem_nz;
  logic        bypass;
  logic [31:0] bypass_result;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        flag_overflow;
  logic        flag_underflow;
  logic        flag_inexact;

  int checks = 0;
  int errors = 0;

  fp_norm_round #(.ROUND_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .op_sel(op_sel), .sign_in(sign_in), .exp_in(exp_in),
    .product_in(product_in), .quotient_in(quotient_in),
    .div_rem_nz(div_rem_nz), .bypass(bypass), .bypass_result(bypass_result),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .flag_overflow(flag_overflow), .flag_underflow(flag_underflow),
    .flag_inexact(flag_inexact)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] flags3();
    return {29'd0, flag_overflow, flag_underflow, flag_inexact};
  endfunction

  task automatic drive(input logic op, input logic s, input logic [9:0] e,
                       input logic [47:0] p, input logic [26:0] q, input logic rem,
                       input logic byp, input logic [31:0] bres);
    op_sel = op; sign_in = s; exp_in = e; product_in = p; quotient_in = q;
    div_rem_nz = rem; bypass = byp; bypass_result = bres;
  endtask

  // Present one op with out_ready=1 and check the packed result two edges later.
  task automatic run_op(input string tag, input logic op, input logic s, input logic [9:0] e,
                        input logic [47:0] p, input logic [26:0] q, input logic rem,
                        input logic [31:0] exp_res, input logic [2:0] exp_flags);
    @(posedge clk); #1;
    drive(op, s, e, p, q, rem, 1'b0, 32'h0);
    in_valid = 1'b1; out_ready = 1'b1;
    #1;
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_result"}, result, exp_res);
    chk({tag, "_flags"}, flags3(), {29'd0, exp_flags});
  endtask

  task automatic stream_op(input int k);
    if (k == 2) drive(1'b0, 1'b0, 10'd0, 48'h0, 27'h0, 1'b0, 1'b1, 32'hDEADBEEF);
    else        drive(1'b0, 1'b0, 10'(100 + k), 48'h400000000000, 27'h0, 1'b0, 1'b0, 32'h0);
  endtask

  logic [31:0] stream_exp [5];
  logic [31:0] held;
  int acc;
  int got;

  initial begin
    stream_exp[0] = 32'h32000000;
    stream_exp[1] = 32'h32800000;
    stream_exp[2] = 32'hDEADBEEF;
    stream_exp[3] = 32'h33800000;
    stream_exp[4] = 32'h34000000;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    drive(1'b0, 1'b0, 10'd0, 48'h0, 27'h0, 1'b0, 1'b0, 32'h0);
    #3;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_result", result, 32'h0);
    chk("rst_flags", flags3(), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // {overflow, underflow, inexact}
    run_op("mul15x15", 1'b0, 1'b0, 10'd127, 48'h900000000000, 27'h0, 1'b0, 32'h40100000, 3'b000);
    run_op("div1by15", 1'b1, 1'b0, 10'd127, 48'h0, 27'h2AAAAAA, 1'b1, 32'h3F2AAAAB, 3'b001);
    run_op("round_carry", 1'b0, 1'b0, 10'd127, 48'h7FFFFFC00000, 27'h0, 1'b0, 32'h40000000, 3'b001);
    run_op("overflow", 1'b0, 1'b1, 10'd254, 48'h800000000000, 27'h0, 1'b0, 32'hFF800000, 3'b101);
    run_op("underflow", 1'b0, 1'b1, 10'd0, 48'h400000000000, 27'h0, 1'b0, 32'h80000000, 3'b011);
    run_op("div_q26", 1'b1, 1'b0, 10'd127, 48'h0, 27'h4000004, 1'b0, 32'h3F800000, 3'b001);

    // Backpressure: out_ready low for cycles 2..6 of a 5-op stream.
    acc = 0; got = 0; held = '0;
    for (int cyc = 0; cyc < 40 && got < 5; cyc++) begin
      @(posedge clk); #1;
      out_ready = !(cyc >= 2 && cyc <= 6);
      if (acc < 5) begin
        stream_op(acc);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (cyc <= 7)
        chk($sformatf("bp_in_ready_c%0d", cyc), {31'd0, in_ready},
            (cyc < 2 || cyc > 6) ? 32'd1 : 32'd0);
      if (cyc == 2) held = result;
      if (cyc >= 3 && cyc <= 6) begin
        chk($sformatf("bp_stall_valid_c%0d", cyc), {31'd0, out_valid}, 32'd1);
        chk($sformatf("bp_stall_hold_c%0d", cyc), result, held);
      end
      if (out_valid && out_ready) begin
        chk($sformatf("bp_result_%0d", got), result, stream_exp[got]);
        chk($sformatf("bp_flags_%0d", got), flags3(), 32'h0);
        got++;
      end
      if (in_valid && in_ready) acc++;
    end
    chk("bp_count", got, 32'd5);
    @(posedge clk); #1;
    in_valid = 1'b0;
    #1;
    chk("bp_drained", {31'd0, out_valid}, 32'd0);

    // Fill both stages under stall, then reset asynchronously.
    @(posedge clk); #1;
    out_ready = 1'b0;
    drive(1'b0, 1'b0, 10'd127, 48'h900000000000, 27'h0, 1'b0, 1'b0, 32'h0);
    in_valid = 1'b1;
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 10'd130, 48'h900000000000, 27'h0, 1'b0, 1'b0, 32'h0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    #1;
    chk("mid_full_valid", {31'd0, out_valid}, 32'd1);
    chk("mid_full_in_ready", {31'd0, in_ready}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_result", result, 32'h0);
    chk("mid_rst_flags", flags3(), 32'h0);
    #2;
    rst_n = 1'b1;
    #1;
    chk("mid_rel_in_ready", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("mid_discarded", {31'd0, out_valid}, 32'd0);
    run_op("post_rst", 1'b0, 1'b1, 10'd127, 48'h900000000000, 27'h0, 1'b0, 32'hC0100000, 3'b000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
